// File: rtl/fu_iq_pkg.sv
// Shared types and default sizing for the per-FU issue queue.
// Entry widths come from the constants here; DEPTH and CDB_PORTS are
// overridable parameters on the top.
package fu_iq_pkg;

    localparam int INST_ID_BITS = 8;
    localparam int PRN_BITS     = 6;
    localparam int MAX_OPERANDS = 3;
    localparam int DATA_BITS    = 64;
    localparam int IQ_DEPTH     = 4;
    localparam int IQ_CDB_PORTS = 2;

    typedef struct packed {
        logic                                     valid;
        logic [INST_ID_BITS-1:0]                  inst_id;
        logic [31:0]                              inst;
        logic [63:0]                              pc;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    src_prn;
        logic [MAX_OPERANDS-1:0]                  src_rdy;
        logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]   src_data;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    out_prn;
    } iq_entry_t;

    // Merge CAM hits into an entry: hit operands become ready with CDB data.
    function automatic iq_entry_t apply_wakeup(
        input iq_entry_t                              e,
        input logic [MAX_OPERANDS-1:0]                hit,
        input logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] data
    );
        iq_entry_t r;
        r = e;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            if (hit[k]) begin
                r.src_rdy[k]  = 1'b1;
                r.src_data[k] = data[k];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fu_iq_wakeup.sv
// Operand CAM for one entry: every not-ready source PRN is compared with all
// valid CDB ports. When several ports carry the same PRN the lowest index wins.
module fu_iq_wakeup
    import fu_iq_pkg::*;
#(
    parameter int CDB_PORTS = IQ_CDB_PORTS
) (
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   src_prn,
    input  logic [MAX_OPERANDS-1:0]                 src_rdy,
    input  logic [CDB_PORTS-1:0]                    cdb_valid,
    input  logic [CDB_PORTS-1:0][PRN_BITS-1:0]      cdb_prn,
    input  logic [CDB_PORTS-1:0][DATA_BITS-1:0]     cdb_data,
    output logic [MAX_OPERANDS-1:0]                 hit,
    output logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]  hit_data
);

    for (genvar k = 0; k < MAX_OPERANDS; k++) begin : g_op
        logic                 match;
        logic [DATA_BITS-1:0] mdata;

        // Scan ports high to low so the lowest matching port overrides.
        always_comb begin
            match = 1'b0;
            mdata = '0;
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (cdb_valid[p] && (cdb_prn[p] == src_prn[k])) begin
                    match = 1'b1;
                    mdata = cdb_data[p];
                end
            end
        end

        assign hit[k]      = match & ~src_rdy[k];
        assign hit_data[k] = mdata;
    end

endmodule

// File: rtl/fu_issue_queue.sv
// Per-FU reservation station: collapsing queue (slot 0 oldest) with CDB
// wakeup and oldest-ready select. iss_* are registered at the removal edge.
// Optional macro FU_IQ_PERF_EN adds saturating issue/stall counters;
// without it perf_issued/perf_stall are constant 0.
module fu_issue_queue
    import fu_iq_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int CDB_PORTS = IQ_CDB_PORTS
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic                                     enq_valid,
    output logic                                     enq_ready,
    input  logic [INST_ID_BITS-1:0]                  enq_inst_id,
    input  logic [31:0]                              enq_inst,
    input  logic [63:0]                              enq_pc,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    enq_src_prn,
    input  logic [MAX_OPERANDS-1:0]                  enq_src_rdy,
    input  logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]   enq_src_data,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    enq_out_prn,
    input  logic [CDB_PORTS-1:0]                     cdb_valid,
    input  logic [CDB_PORTS-1:0][PRN_BITS-1:0]       cdb_prn,
    input  logic [CDB_PORTS-1:0][DATA_BITS-1:0]      cdb_data,
    input  logic                                     fu_busy,
    output logic                                     iss_valid,
    output logic [INST_ID_BITS-1:0]                  iss_inst_id,
    output logic [31:0]                              iss_inst,
    output logic [63:0]                              iss_pc,
    output logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]   iss_op,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    iss_out_prn,
    output logic [$clog2(DEPTH+1)-1:0]               occupancy,
    output logic [31:0]                              perf_issued,
    output logic [31:0]                              perf_stall
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    iq_entry_t ent_q   [DEPTH];
    iq_entry_t ent_wk  [DEPTH];
    iq_entry_t ent_nxt [DEPTH];
    iq_entry_t enq_raw;
    iq_entry_t enq_ent;

    logic [DEPTH-1:0][MAX_OPERANDS-1:0]                wk_hit;
    logic [DEPTH-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] wk_data;
    logic [MAX_OPERANDS-1:0]                           enq_hit;
    logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]            enq_hdata;

    logic [DEPTH-1:0] ent_rdy;
    logic [CW-1:0]    cnt_q, cnt_nxt, enq_slot;
    logic [IW-1:0]    sel_idx;
    logic             sel_any, sel_vld, enq_fire, iss_fire;

    // Ready is based only on the registered count, never on this cycle's issue.
    assign enq_ready = (cnt_q < CW'(DEPTH));
    assign enq_fire  = enq_valid && enq_ready;
    assign occupancy = cnt_q;
    assign iss_fire  = sel_vld && !flush;

    // Wakeup CAM per stored entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        fu_iq_wakeup #(.CDB_PORTS(CDB_PORTS)) u_wk (
            .src_prn   (ent_q[i].src_prn),
            .src_rdy   (ent_q[i].src_rdy),
            .cdb_valid (cdb_valid),
            .cdb_prn   (cdb_prn),
            .cdb_data  (cdb_data),
            .hit       (wk_hit[i]),
            .hit_data  (wk_data[i])
        );
        assign ent_wk[i]  = apply_wakeup(ent_q[i], wk_hit[i], wk_data[i]);
        assign ent_rdy[i] = ent_q[i].valid && (&ent_q[i].src_rdy);
    end

    // Incoming instruction, before same-cycle wakeup.
    always_comb begin
        enq_raw          = '0;
        enq_raw.valid    = 1'b1;
        enq_raw.inst_id  = enq_inst_id;
        enq_raw.inst     = enq_inst;
        enq_raw.pc       = enq_pc;
        enq_raw.src_prn  = enq_src_prn;
        enq_raw.src_rdy  = enq_src_rdy;
        enq_raw.src_data = enq_src_data;
        enq_raw.out_prn  = enq_out_prn;
    end

    // Enqueue-path CAM so a broadcast in the enqueue cycle is not lost.
    fu_iq_wakeup #(.CDB_PORTS(CDB_PORTS)) u_enq_wk (
        .src_prn   (enq_src_prn),
        .src_rdy   (enq_src_rdy),
        .cdb_valid (cdb_valid),
        .cdb_prn   (cdb_prn),
        .cdb_data  (cdb_data),
        .hit       (enq_hit),
        .hit_data  (enq_hdata)
    );
    assign enq_ent = apply_wakeup(enq_raw, enq_hit, enq_hdata);

    // Oldest-ready select: lowest slot whose operands are all ready.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_rdy[i]) begin
                sel_any = 1'b1;
                sel_idx = IW'(i);
            end
        end
        sel_vld = sel_any && !fu_busy;
    end

    // Next queue image: collapse over the issued slot, then append.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_nxt[i] = ent_wk[i];
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (sel_vld && (i >= int'(sel_idx))) ent_nxt[i] = ent_wk[i+1];
        end
        if (sel_vld) ent_nxt[DEPTH-1] = '0;
        enq_slot = cnt_q - CW'(sel_vld);
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_fire && (CW'(i) == enq_slot)) ent_nxt[i] = enq_ent;
        end
        cnt_nxt = cnt_q + CW'(enq_fire) - CW'(sel_vld);
    end

    // Queue state register; flush empties the queue and drops any enqueue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_nxt[i];
            cnt_q <= cnt_nxt;
        end
    end

    // Issue register: one-cycle valid pulse, payload holds between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid   <= 1'b0;
            iss_inst_id <= '0;
            iss_inst    <= '0;
            iss_pc      <= '0;
            iss_op      <= '0;
            iss_out_prn <= '0;
        end else if (flush) begin
            iss_valid   <= 1'b0;
        end else begin
            iss_valid   <= sel_vld;
            if (sel_vld) begin
                iss_inst_id <= ent_q[sel_idx].inst_id;
                iss_inst    <= ent_q[sel_idx].inst;
                iss_pc      <= ent_q[sel_idx].pc;
                iss_op      <= ent_q[sel_idx].src_data;
                iss_out_prn <= ent_q[sel_idx].out_prn;
            end
        end
    end

`ifdef FU_IQ_PERF_EN
    logic [31:0] issued_q, stall_q;

    // Saturating counters; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (iss_fire && !(&issued_q)) issued_q <= issued_q + 32'd1;
            if (enq_valid && !enq_ready && !(&stall_q)) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`else
    logic unused_perf;
    assign unused_perf = iss_fire;
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_fu_issue_queue.sv
// Self-checking bench for fu_issue_queue: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_fu_issue_queue;

    localparam int DEPTH = 4;
    localparam int NOP   = 3;
    localparam int NCDB  = 2;
`ifdef FU_IQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst, flush, enq_valid, fu_busy;
    logic                  enq_ready, iss_valid;
    logic [7:0]            enq_inst_id, iss_inst_id;
    logic [31:0]           enq_inst, iss_inst;
    logic [63:0]           enq_pc, iss_pc;
    logic [NOP-1:0][5:0]   enq_src_prn, enq_out_prn, iss_out_prn;
    logic [NOP-1:0]        enq_src_rdy;
    logic [NOP-1:0][63:0]  enq_src_data, iss_op;
    logic [NCDB-1:0]       cdb_valid;
    logic [NCDB-1:0][5:0]  cdb_prn;
    logic [NCDB-1:0][63:0] cdb_data;
    logic [2:0]            occupancy;
    logic [31:0]           perf_issued, perf_stall;

    fu_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_inst_id(enq_inst_id), .enq_inst(enq_inst), .enq_pc(enq_pc),
        .enq_src_prn(enq_src_prn), .enq_src_rdy(enq_src_rdy),
        .enq_src_data(enq_src_data), .enq_out_prn(enq_out_prn),
        .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_data(cdb_data),
        .fu_busy(fu_busy),
        .iss_valid(iss_valid), .iss_inst_id(iss_inst_id), .iss_inst(iss_inst),
        .iss_pc(iss_pc), .iss_op(iss_op), .iss_out_prn(iss_out_prn),
        .occupancy(occupancy), .perf_issued(perf_issued), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    // Reference model: an age-ordered queue of instructions.
    typedef struct {
        logic [7:0]  id;
        logic [31:0] inst;
        logic [63:0] pc;
        logic [5:0]  prn  [NOP];
        bit          rdy  [NOP];
        logic [63:0] data [NOP];
        logic [5:0]  outp [NOP];
    } m_ent_t;

    m_ent_t      mq[$];
    bit          e_valid;
    logic [7:0]  e_id;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic [63:0] e_op  [NOP];
    logic [5:0]  e_out [NOP];
    logic [31:0] e_issued, e_stall;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic m_ent_t wake(input m_ent_t e);
        m_ent_t r;
        r = e;
        for (int k = 0; k < NOP; k++) begin
            if (!r.rdy[k]) begin
                for (int p = 0; p < NCDB; p++) begin
                    if (cdb_valid[p] && cdb_prn[p] == r.prn[k]) begin
                        r.data[k] = cdb_data[p];
                        r.rdy[k]  = 1'b1;
                        break;
                    end
                end
            end
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs now driven.
    task automatic model_step();
        int     osz, idx;
        bit     all;
        m_ent_t n;
        osz = mq.size();
        if (rst) begin
            mq.delete();
            e_valid = 1'b0; e_id = '0; e_inst = '0; e_pc = '0;
            for (int k = 0; k < NOP; k++) begin e_op[k] = '0; e_out[k] = '0; end
            e_issued = '0; e_stall = '0;
            return;
        end
        if (PERF && enq_valid && osz >= DEPTH && e_stall != 32'hFFFF_FFFF) e_stall++;
        if (flush) begin
            mq.delete();
            e_valid = 1'b0;
            return;
        end
        e_valid = 1'b0;
        if (!fu_busy) begin
            idx = -1;
            for (int i = 0; i < mq.size(); i++) begin
                all = 1'b1;
                for (int k = 0; k < NOP; k++) if (!mq[i].rdy[k]) all = 1'b0;
                if (all) begin idx = i; break; end
            end
            if (idx >= 0) begin
                e_valid = 1'b1;
                e_id = mq[idx].id; e_inst = mq[idx].inst; e_pc = mq[idx].pc;
                for (int k = 0; k < NOP; k++) begin
                    e_op[k] = mq[idx].data[k]; e_out[k] = mq[idx].outp[k];
                end
                mq.delete(idx);
                if (PERF && e_issued != 32'hFFFF_FFFF) e_issued++;
            end
        end
        for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
        if (enq_valid && osz < DEPTH) begin
            n.id = enq_inst_id; n.inst = enq_inst; n.pc = enq_pc;
            for (int k = 0; k < NOP; k++) begin
                n.prn[k] = enq_src_prn[k]; n.rdy[k] = enq_src_rdy[k];
                n.data[k] = enq_src_data[k]; n.outp[k] = enq_out_prn[k];
            end
            mq.push_back(wake(n));
        end
    endtask

    task automatic compare_all();
        chk("iss_valid",   64'(iss_valid),   64'(e_valid));
        chk("iss_inst_id", 64'(iss_inst_id), 64'(e_id));
        chk("iss_inst",    64'(iss_inst),    64'(e_inst));
        chk("iss_pc",      iss_pc,           e_pc);
        for (int k = 0; k < NOP; k++) begin
            chk("iss_op",      iss_op[k],             e_op[k]);
            chk("iss_out_prn", 64'(iss_out_prn[k]),   64'(e_out[k]));
        end
        chk("occupancy",   64'(occupancy),   64'(mq.size()));
        chk("enq_ready",   64'(enq_ready),   64'(mq.size() < DEPTH));
        chk("perf_issued", 64'(perf_issued), 64'(e_issued));
        chk("perf_stall",  64'(perf_stall),  64'(e_stall));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        enq_valid = 1'b0; cdb_valid = '0; flush = 1'b0;
    endtask

    task automatic drive_enq(input logic [7:0] id, input logic [2:0] rdy, input logic [5:0] p0);
        enq_valid    = 1'b1;
        enq_inst_id  = id;
        enq_inst     = 32'h1000 + 32'(id);
        enq_pc       = 64'h4000 + 64'(id) * 64'd4;
        enq_src_prn  = {6'd0, 6'd0, p0};
        enq_src_rdy  = rdy;
        enq_src_data = {64'h30 + 64'(id), 64'h20 + 64'(id), 64'h10 + 64'(id)};
        enq_out_prn  = {6'd3, 6'd2, 6'd1};
    endtask

    task automatic do_reset();
        idle(); fu_busy = 1'b0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; fu_busy = 1'b0;
        enq_inst_id = '0; enq_inst = '0; enq_pc = '0; enq_src_prn = '0;
        enq_src_rdy = '0; enq_src_data = '0; enq_out_prn = '0;
        cdb_valid = '0; cdb_prn = '0; cdb_data = '0;

        do_reset();
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_iss_id",    64'(iss_inst_id), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);

        // Fully ready enqueue issues two edges later.
        drive_enq(8'h05, 3'b111, 6'd0); tick(); idle();
        chk("t1_no_early", 64'(iss_valid), 64'd0);
        tick();
        chk("t1_iss_valid", 64'(iss_valid), 64'd1);
        chk("t1_iss_id",    64'(iss_inst_id), 64'h05);
        chk("t1_iss_pc",    iss_pc, 64'h4014);
        chk("t1_occ",       64'(occupancy), 64'd0);
        tick();
        chk("t1_pulse_end", 64'(iss_valid), 64'd0);
        chk("t1_hold_id",   64'(iss_inst_id), 64'h05);

        // Younger ready entry bypasses older waiting one; port 0 wins on PRN tie.
        drive_enq(8'h01, 3'b110, 6'd9); tick();
        drive_enq(8'h02, 3'b111, 6'd0); tick(); idle();
        cdb_valid = 2'b11; cdb_prn = {6'd9, 6'd9}; cdb_data = {64'hCD, 64'hAB};
        tick(); idle();
        chk("t2_first_id", 64'(iss_inst_id), 64'h02);
        chk("t2_first_v",  64'(iss_valid), 64'd1);
        tick();
        chk("t2_second_v",  64'(iss_valid), 64'd1);
        chk("t2_second_id", 64'(iss_inst_id), 64'h01);
        chk("t2_op0",       iss_op[0], 64'hAB);

        // Wakeup in the enqueue cycle.
        drive_enq(8'h03, 3'b110, 6'd12);
        cdb_valid = 2'b10; cdb_prn = {6'd12, 6'd0}; cdb_data = {64'h77, 64'h0};
        tick(); idle();
        tick();
        chk("t3_iss_v",  64'(iss_valid), 64'd1);
        chk("t3_op0",    iss_op[0], 64'h77);

        // Fill while FU busy, 3 blocked cycles, then drain in slot order.
        do_reset();
        fu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin drive_enq(8'h10 + 8'(i), 3'b111, 6'd0); tick(); end
        drive_enq(8'h20, 3'b111, 6'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t4_ready", 64'(enq_ready), 64'd0);
        chk("t4_occ",   64'(occupancy), 64'd4);
        chk("t4_noiss", 64'(iss_valid), 64'd0);
        idle(); fu_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_drain_v",  64'(iss_valid), 64'd1);
            chk("t4_drain_id", 64'(iss_inst_id), 64'h10 + 64'(i));
        end
        tick();
        chk("t6_issued", 64'(perf_issued), PERF ? 64'd4 : 64'd0);
        chk("t6_stall",  64'(perf_stall),  PERF ? 64'd3 : 64'd0);

        // Flush with 3 valid entries and an enqueue offered.
        fu_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin drive_enq(8'h40 + 8'(i), 3'b111, 6'd0); tick(); end
        drive_enq(8'h99, 3'b111, 6'd0); flush = 1'b1;
        tick(); idle(); fu_busy = 1'b0;
        chk("t5_occ",    64'(occupancy), 64'd0);
        chk("t5_iss_v",  64'(iss_valid), 64'd0);
        tick(); tick();
        chk("t5_absent", 64'(iss_valid), 64'd0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            enq_valid = ($urandom_range(0, 9) < 6);
            fu_busy   = ($urandom_range(0, 9) < 3);
            enq_inst_id = 8'($urandom);
            enq_inst    = $urandom;
            enq_pc      = {$urandom, $urandom};
            enq_src_rdy = 3'($urandom);
            for (int k = 0; k < NOP; k++) begin
                enq_src_prn[k]  = 6'($urandom_range(0, 15));
                enq_src_data[k] = {$urandom, $urandom};
                enq_out_prn[k]  = 6'($urandom);
            end
            cdb_valid = 2'($urandom);
            for (int p = 0; p < NCDB; p++) begin
                cdb_prn[p]  = 6'($urandom_range(0, 15));
                cdb_data[p] = {$urandom, $urandom};
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
